// File: rtl/imem_dmem_port_arbiter_if.sv
// Request/grant/rvalid memory port shared by fetch, LSU and the memory side.
// The master issues requests; the slave grants them and returns responses.
interface imem_dmem_port_arbiter_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/imem_dmem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between instruction fetch and the LSU,
// with a starvation guard for fetch and an in-order ID FIFO for response routing.
module imem_dmem_port_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic                            clk,
  input  logic                            rstn,
  imem_dmem_port_arbiter_if.slave         instr,
  imem_dmem_port_arbiter_if.slave         data,
  imem_dmem_port_arbiter_if.master        mem,
  output logic                            protocol_err_o
);

  localparam int unsigned PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  localparam logic ID_INSTR = 1'b0;
  localparam logic ID_DATA  = 1'b1;

  // Lock state: which requester owns the port while its request waits for gnt.
  localparam logic [1:0] ST_FREE   = 2'd0;
  localparam logic [1:0] ST_LOCK_I = 2'd1;
  localparam logic [1:0] ST_LOCK_D = 2'd2;

  logic [1:0]          lock_state;
  logic [1:0]          lock_state_next;
  logic [STARVE_W-1:0] starve_cnt;
  logic [CNT_W-1:0]    count;
  logic [PTR_W-1:0]    wptr;
  logic [PTR_W-1:0]    rptr;
  logic                ids [MAX_OUTSTANDING];

  logic win_data;
  logic win_req;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic head_id;
  logic starved;

  // Fetch has no write path; its write-side bus fields are intentionally ignored.
  logic unused_instr_write;
  assign unused_instr_write = ^{instr.we, instr.be, instr.wdata};

  assign fifo_full  = (count == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count == '0);
  assign starved    = (starve_cnt == STARVE_W'(STARVE_LIMIT));
  assign head_id    = ids[rptr];

  // NOTE: every signal assigned in a combinational block gets a default first,
  // so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    win_data = ID_DATA;
    case (lock_state)
      ST_LOCK_I: win_data = ID_INSTR;
      ST_LOCK_D: win_data = ID_DATA;
      default:   win_data = (instr.req && (!data.req || starved)) ? ID_INSTR : ID_DATA;
    endcase
  end

  assign win_req = win_data ? data.req : instr.req;

  assign mem.req   = win_req & ~fifo_full;
  assign mem.we    = win_data ? data.we    : 1'b0;
  assign mem.be    = win_data ? data.be    : 4'hF;
  assign mem.addr  = win_data ? data.addr  : instr.addr;
  assign mem.wdata = win_data ? data.wdata : 32'h0;

  assign instr.gnt = mem.gnt & mem.req & (win_data == ID_INSTR);
  assign data.gnt  = mem.gnt & mem.req & (win_data == ID_DATA);

  assign push = mem.req & mem.gnt;
  assign pop  = mem.rvalid & ~fifo_empty;

  // Responses go to the owner at the FIFO head; data and error are broadcast.
  assign instr.rvalid = pop & (head_id == ID_INSTR);
  assign data.rvalid  = pop & (head_id == ID_DATA);
  assign instr.rdata  = mem.rdata;
  assign data.rdata   = mem.rdata;
  assign instr.err    = mem.err;
  assign data.err     = mem.err;

  always_comb begin
    lock_state_next = lock_state;
    if (mem.req && !mem.gnt) begin
      lock_state_next = win_data ? ST_LOCK_D : ST_LOCK_I;
    end else if (push) begin
      lock_state_next = ST_FREE;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lock_state <= ST_FREE;
    end else begin
      lock_state <= lock_state_next;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= '0;
    end else if (!instr.req || instr.gnt) begin
      starve_cnt <= '0;
    end else if (win_data == ID_DATA && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= (wptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wptr + 1'b1;
      end
      if (pop) begin
        rptr <= (rptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the ID storage has no reset; entries are only read while count says
  // they are valid, and reset already empties the FIFO through the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      ids[wptr] <= win_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      protocol_err_o <= 1'b0;
    end else if (mem.rvalid && fifo_empty) begin
      protocol_err_o <= 1'b1;
    end
  end

endmodule
